// File: rtl/src_mem_pkg.sv
// Shared types and sizing for the SRC main-memory arbiter.
package src_mem_pkg;

  localparam int unsigned SRC_ADDR_W      = 16;
  localparam int unsigned SRC_DATA_W      = 32;
  localparam int unsigned SRC_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  // Counter must hold WAIT_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles < 2) ? 1 : $clog2(wait_cycles + 1);
  endfunction

  localparam int unsigned SRC_CNT_W = cnt_width(SRC_WAIT_CYCLES);

endpackage

// File: rtl/src_rr_arb2.sv
// Combinational 2-way round-robin arbiter; the 'last' register lives in the parent.
module src_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = '0;
    grant_idx = (req == 2'b11) ? ~last : req[1];
    if (|req) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/src_mem_arbiter.sv
// Round-robin sequencer sharing the SRC main memory between fetch (port 0)
// and load/store (port 1), with fixed wait cycles and a one-cycle done pulse.
module src_mem_arbiter
  import src_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = SRC_ADDR_W,
  parameter int unsigned DATA_W      = SRC_DATA_W,
  parameter int unsigned WAIT_CYCLES = SRC_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned      CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t        r_state;
  mem_state_t        w_next_state;
  logic              r_last;
  logic              r_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_en;
  logic [DATA_W-1:0] r_rdata;
  logic              r_done0;
  logic              r_done1;
  logic              r_busy;

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_grant_idx;
  logic              w_grant_en;
  logic              w_capture;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_we;

  assign w_req = {req1, req0};

  src_rr_arb2 u_arb (
    .req       (w_req),
    .last      (r_last),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_win_addr  = w_grant_idx ? addr1  : addr0;
  assign w_win_wdata = w_grant_idx ? wdata1 : wdata0;
  assign w_win_we    = w_grant_idx ? we1    : we0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_grant_en   = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_grant_en   = 1'b1;
          w_cnt_next   = CNT_LOAD;
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_capture    = ~r_mem_we;
          w_next_state = DONE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so every output comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_rdata     <= '0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_mem_en <= (w_next_state == ACCESS);
      r_busy   <= (w_next_state != IDLE);
      r_done0  <= (w_next_state == DONE) && !r_owner;
      r_done1  <= (w_next_state == DONE) &&  r_owner;
      if (w_grant_en) begin
        r_mem_addr  <= w_win_addr;
        r_mem_wdata <= w_win_wdata;
        r_mem_we    <= w_win_we;
        r_owner     <= w_grant_idx;
        r_last      <= w_grant_idx;
      end
      if (w_capture) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign done0     = r_done0;
  assign done1     = r_done1;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;

endmodule
